// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the pipelined CORDIC engine
package cordic_pkg;
  localparam int ATAN_LUT [0:14] = '{4500, 2657, 1404, 713, 358, 179, 90, 45, 22, 11, 6, 3, 1, 1, 0};
  localparam int K_Q15 = 19898;
  localparam int ANG_90 = 9000;
  localparam int ANG_180 = 18000;
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation carrying valid, mode and tag
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW = 18,
  parameter int ZW = 17,
  parameter int TW = 5,
  parameter int SHIFT = 0,
  parameter int ATAN = 4500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_mode,
  input  logic [TW-1:0]        in_tag,
  input  logic signed [XW-1:0] in_x,
  input  logic signed [XW-1:0] in_y,
  input  logic signed [ZW-1:0] in_z,
  output logic                 out_valid,
  output logic                 out_mode,
  output logic [TW-1:0]        out_tag,
  output logic signed [XW-1:0] out_x,
  output logic signed [XW-1:0] out_y,
  output logic signed [ZW-1:0] out_z
);
  localparam logic signed [ZW-1:0] A = ZW'(ATAN);
  logic up;
  logic signed [XW-1:0] xs, ys;
  assign up = (in_mode == MODE_VEC) ? in_y[XW-1] : !in_z[ZW-1];
  assign xs = in_x >>> SHIFT;
  assign ys = in_y >>> SHIFT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      out_x     <= up ? in_x - ys : in_x + ys;
      out_y     <= up ? in_y + xs : in_y - xs;
      out_z     <= up ? in_z - A : in_z + A;
    end
endmodule

// File: rtl/cordic_pipe_engine.sv
// cordic_pipe_engine: global-stall CORDIC pipeline, rotation or vectoring per sample
module cordic_pipe_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ANG_W = 16,
  parameter int ITER = 14,
  parameter int GAIN_COMP = 1,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [ANG_W-1:0] in_z,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [ANG_W-1:0] out_z,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int XW = WIDTH + 2;
  localparam int ZW = ANG_W + 1;
  localparam int TW = TAG_W + 1;
  localparam int PW = XW + 16;
  localparam logic signed [ZW-1:0] Z90 = ZW'(ANG_90);
  localparam logic signed [ZW-1:0] Z180 = ZW'(ANG_180);
  localparam logic signed [ZW-1:0] ZMAX = ZW'((1 << (ANG_W - 1)) - 1);
  localparam logic signed [ZW-1:0] ZMIN = -ZMAX - ZW'(1);
  localparam logic signed [PW-1:0] KQ = PW'(K_Q15);
  localparam logic signed [PW-1:0] RND = PW'(1 << 14);
  localparam logic signed [PW-1:0] XMAX = PW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] XMIN = -XMAX - PW'(1);
  logic adv, neg, zero;
  logic signed [XW-1:0] xi, yi;
  logic signed [ZW-1:0] zi, z0;
  logic pv, pm;
  logic [TW-1:0] pt;
  logic signed [XW-1:0] px, py;
  logic signed [ZW-1:0] pz;
  logic v [0:ITER];
  logic m [0:ITER];
  logic [TW-1:0] t [0:ITER];
  logic signed [XW-1:0] x [0:ITER];
  logic signed [XW-1:0] y [0:ITER];
  logic signed [ZW-1:0] z [0:ITER];
  logic signed [PW-1:0] xe, ye, gx, gy;
  logic signed [ANG_W-1:0] zs;
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] a);
    return a > XMAX ? XMAX[WIDTH-1:0] : a < XMIN ? XMIN[WIDTH-1:0] : a[WIDTH-1:0];
  endfunction
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign xi = {{2{in_x[WIDTH-1]}}, in_x};
  assign yi = {{2{in_y[WIDTH-1]}}, in_y};
  assign zi = {in_z[ANG_W-1], in_z};
  // vectoring x<0 folds into the right half-plane and seeds z with +/-180 by sign of y
  always_comb begin
    zero = (in_mode == MODE_VEC) && xi == '0 && yi == '0;
    neg = (in_mode == MODE_VEC) ? xi[XW-1] : (zi > Z90 || zi < -Z90);
    z0 = (in_mode == MODE_VEC) ? (!xi[XW-1] ? ZW'(0) : yi[XW-1] ? -Z180 : Z180)
       : (zi > Z90) ? zi - Z180 : (zi < -Z90) ? zi + Z180 : zi;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pv <= 1'b0;
      pm <= 1'b0;
      pt <= '0;
      px <= '0;
      py <= '0;
      pz <= '0;
    end else if (adv) begin
      pv <= in_valid;
      pm <= in_mode;
      pt <= {zero, in_tag};
      px <= neg ? -xi : xi;
      py <= neg ? -yi : yi;
      pz <= z0;
    end
  assign v[0] = pv;
  assign m[0] = pm;
  assign t[0] = pt;
  assign x[0] = px;
  assign y[0] = py;
  assign z[0] = pz;
  for (genvar g = 0; g < ITER; g++) begin : stg
    cordic_stage #(.XW(XW), .ZW(ZW), .TW(TW), .SHIFT(g), .ATAN(ATAN_LUT[g])) u_stage (
      .clk(clk), .rst(rst), .en(adv),
      .in_valid(v[g]), .in_mode(m[g]), .in_tag(t[g]), .in_x(x[g]), .in_y(y[g]), .in_z(z[g]),
      .out_valid(v[g+1]), .out_mode(m[g+1]), .out_tag(t[g+1]),
      .out_x(x[g+1]), .out_y(y[g+1]), .out_z(z[g+1])
    );
  end
  assign xe = {{16{x[ITER][XW-1]}}, x[ITER]};
  assign ye = {{16{y[ITER][XW-1]}}, y[ITER]};
  assign gx = (GAIN_COMP != 0) ? ((xe * KQ + RND) >>> 15) : xe;
  assign gy = (GAIN_COMP != 0) ? ((ye * KQ + RND) >>> 15) : ye;
  assign zs = z[ITER] > ZMAX ? ZMAX[ANG_W-1:0] : z[ITER] < ZMIN ? ZMIN[ANG_W-1:0] : z[ITER][ANG_W-1:0];
  // the spare tag bit marks a zero vector, whose angle would otherwise drift to the LUT sum
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (adv) begin
      out_valid <= v[ITER];
      out_tag   <= t[ITER][TAG_W-1:0];
      out_x     <= sat(gx);
      out_y     <= sat(gy);
      out_z     <= (m[ITER] == MODE_VEC && t[ITER][TAG_W]) ? '0 : zs;
    end
endmodule

// File: tb/tb_cordic_pipe_engine.sv
// tb_cordic_pipe_engine: randomized and directed checks against a trigonometric reference
module tb_cordic_pipe_engine;
  localparam int W = 16;
  localparam int AW = 16;
  localparam int IT = 14;
  localparam int TW = 4;
  localparam int LAT = IT + 2;
  localparam real PI = 3.14159265358979;

  logic clk = 0, rst = 1, in_valid = 0, in_mode = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic signed [W-1:0] in_x = '0, in_y = '0, out_x, out_y;
  logic signed [AW-1:0] in_z = '0, out_z;
  logic [TW-1:0] in_tag = '0, out_tag;

  typedef struct {bit mode; int tag; int ex; int ey; int ez; int cyc;} exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0;

  cordic_pipe_engine #(.WIDTH(W), .ANG_W(AW), .ITER(IT), .GAIN_COMP(1), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int a);
    return a < 0 ? -a : a;
  endfunction

  // Ideal rotation (gain-compensated) or polar conversion, from real arithmetic
  function automatic exp_t model(input bit mode, input int xv, input int yv, input int zv, input int tg, input int cyc);
    exp_t e;
    real th;
    e.mode = mode;
    e.tag = tg;
    e.cyc = cyc;
    if (!mode) begin
      th = real'(zv) * PI / 18000.0;
      e.ex = int'(xv * $cos(th) - yv * $sin(th));
      e.ey = int'(xv * $sin(th) + yv * $cos(th));
      e.ez = 0;
    end else begin
      e.ex = int'($sqrt(real'(xv * xv + yv * yv)));
      e.ey = 0;
      e.ez = (xv == 0 && yv == 0) ? 0 : int'($atan2(real'(yv), real'(xv)) * 18000.0 / PI);
    end
    return e;
  endfunction

  task automatic gen(output bit m, output int xv, output int yv, output int zv, output int tg);
    m = 1'($urandom_range(1));
    tg = int'($urandom_range(15));
    xv = int'($urandom_range(14000)) - 7000;
    yv = int'($urandom_range(14000)) - 7000;
    zv = int'($urandom_range(36000)) - 18000;
    while (m && iabs(xv) < 4000 && iabs(yv) < 4000) xv = int'($urandom_range(14000)) - 7000;
  endtask

  task automatic drive(input bit m, input int xv, input int yv, input int zv, input int tg);
    in_mode = m;
    in_x = xv[W-1:0];
    in_y = yv[W-1:0];
    in_z = zv[AW-1:0];
    in_tag = tg[TW-1:0];
  endtask

  task automatic run_one(input bit m, input int xv, input int yv, input int zv, input int tg,
                         output int ox, output int oy, output int oz, output int ot, output int lat);
    @(negedge clk);
    drive(m, xv, yv, zv, tg);
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    lat = -1;
    ox = 0; oy = 0; oz = 0; ot = -1;
    for (int k = 1; k <= LAT + 20; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        lat = k; ox = out_x; oy = out_y; oz = out_z; ot = int'(out_tag);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1 rst = 0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ctl out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    nvec++;
    if ({out_x, out_y, out_z, out_tag} !== '0) begin
      nerr++; $display("FAIL reset_data x=%0d y=%0d z=%0d tag=%0d want 0", out_x, out_y, out_z, out_tag);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_rotation;
    int rz [7] = '{3000, 13500, -13500, 18000, 9000, -18000, 0};
    int rx [7] = '{8660, -7071, -7071, -10000, 0, -10000, 10000};
    int ry [7] = '{5000, 7071, -7071, 0, 10000, 0, 0};
    int ox, oy, oz, ot, lat;
    for (int i = 0; i < 7; i++) begin
      run_one(0, 10000, 0, rz[i], i, ox, oy, oz, ot, lat);
      nvec++;
      if (lat !== LAT) begin nerr++; $display("FAIL rot_latency z=%0d got %0d want %0d", rz[i], lat, LAT); end
      nvec++;
      if (iabs(ox - rx[i]) > 20 || iabs(oy - ry[i]) > 20) begin
        nerr++; $display("FAIL rot_xy z=%0d got (%0d,%0d) want (%0d,%0d)+/-20", rz[i], ox, oy, rx[i], ry[i]);
      end
      nvec++;
      if (iabs(oz) > 10 || ot !== i) begin
        nerr++; $display("FAIL rot_z_tag z=%0d got z=%0d tag=%0d want ~0 tag=%0d", rz[i], oz, ot, i);
      end
    end
  endtask

  task automatic test_vectoring;
    int vx [4] = '{-6000, 0, 3000, -5000};
    int vy [4] = '{-8000, 0, 4000, 0};
    int vm [4] = '{10000, 0, 5000, 5000};
    int va [4] = '{-12687, 0, 5313, 18000};
    int ox, oy, oz, ot, lat;
    for (int i = 0; i < 4; i++) begin
      run_one(1, vx[i], vy[i], 0, 9 + i, ox, oy, oz, ot, lat);
      nvec++;
      if (lat !== LAT || ot !== 9 + i) begin
        nerr++; $display("FAIL vec_lat_tag (%0d,%0d) got lat=%0d tag=%0d want %0d/%0d", vx[i], vy[i], lat, ot, LAT, 9 + i);
      end
      nvec++;
      if ((i == 1) ? (ox !== 0 || oz !== 0) : (iabs(ox - vm[i]) > 20 || iabs(oz - va[i]) > 10 || iabs(oy) > 20)) begin
        nerr++; $display("FAIL vec_result (%0d,%0d) got mag=%0d y=%0d z=%0d want mag=%0d z=%0d", vx[i], vy[i], ox, oy, oz, vm[i], va[i]);
      end
    end
  endtask

  task automatic test_stream(input int n, input int rpct, input bit chk_lat, input string nm);
    int sent = 0, got = 0, cyc = 0, cx, cy, cz, ct;
    bit cm, hv = 0;
    logic signed [W-1:0] hx = '0, hy = '0;
    logic signed [AW-1:0] hz = '0;
    logic [TW-1:0] ht = '0;
    exp_t e;
    q.delete();
    gen(cm, cx, cy, cz, ct);
    while (got < n && cyc < n * 8 + 100) begin
      @(negedge clk);
      drive(cm, cx, cy, cz, ct);
      in_valid = (sent < n) && (chk_lat || $urandom_range(99) < 80);
      out_ready = $urandom_range(99) < rpct;
      #1;
      nvec++;
      if (in_ready !== (!out_valid || out_ready)) begin
        nerr++; $display("FAIL %s in_ready cyc=%0d got %b want %b", nm, cyc, in_ready, !out_valid || out_ready);
      end
      if (hv) begin
        nvec++;
        if (out_valid !== 1'b1 || {out_x, out_y, out_z, out_tag} !== {hx, hy, hz, ht}) begin
          nerr++; $display("FAIL %s stall_hold cyc=%0d got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", nm, cyc, out_x, out_y, out_z, out_tag, hx, hy, hz, ht);
        end
      end
      if (out_valid && out_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL %s extra_output cyc=%0d got tag=%0d want none", nm, cyc, out_tag);
        end else begin
          e = q.pop_front();
          got++;
          if (int'(out_tag) !== e.tag) begin
            nerr++; $display("FAIL %s tag #%0d got %0d want %0d", nm, got, out_tag, e.tag);
          end
          nvec++;
          if (iabs(out_x - e.ex) > 20 || iabs(out_y - e.ey) > 20 || iabs(out_z - e.ez) > (e.mode ? 15 : 10)) begin
            nerr++; $display("FAIL %s value #%0d mode=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", nm, got, e.mode, out_x, out_y, out_z, e.ex, e.ey, e.ez);
          end
          if (chk_lat) begin
            nvec++;
            if (cyc - e.cyc !== LAT) begin
              nerr++; $display("FAIL %s latency #%0d got %0d want %0d", nm, got, cyc - e.cyc, LAT);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(cm, cx, cy, cz, ct, cyc));
        sent++;
        gen(cm, cx, cy, cz, ct);
      end
      hv = out_valid && !out_ready;
      hx = out_x; hy = out_y; hz = out_z; ht = out_tag;
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    nvec++;
    if (got !== n || q.size() != 0) begin
      nerr++; $display("FAIL %s count got %0d left %0d want %0d left 0", nm, got, q.size(), n);
    end
  endtask

  task automatic test_reset_mid;
    int cx, cy, cz, ct, ox, oy, oz, ot, lat, seen;
    bit cm, full = 0;
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      gen(cm, cx, cy, cz, ct);
      drive(cm, cx, cy, cz, ct);
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    for (int k = 0; k < 40 && !full; k++) begin
      #1;
      full = out_valid;
      if (!full) @(negedge clk);
    end
    nvec++;
    if (!full) begin nerr++; $display("FAIL rstmid fill got out_valid=0 want 1"); end
    @(negedge clk);
    #2 rst = 0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_x !== '0 || out_tag !== '0) begin
      nerr++; $display("FAIL rstmid clear got v=%b x=%0d tag=%0d want 0", out_valid, out_x, out_tag);
    end
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    seen = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    nvec++;
    if (seen !== 0) begin nerr++; $display("FAIL rstmid dropped got %0d outputs want 0", seen); end
    run_one(0, 10000, 0, 3000, 5, ox, oy, oz, ot, lat);
    nvec++;
    if (lat !== LAT || ot !== 5 || iabs(ox - 8660) > 20 || iabs(oy - 5000) > 20) begin
      nerr++; $display("FAIL rstmid first got lat=%0d tag=%0d (%0d,%0d) want %0d 5 (8660,5000)", lat, ot, ox, oy, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_vectoring;
    test_stream(50, 100, 1, "stream");
    test_stream(200, 50, 0, "backpressure");
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
